// File: rtl/tetris_pkg.sv
// Shared types and constants for the TETRIS gravity timer: level-to-period
// mapping and the drop timer state encoding.
package tetris_pkg;

  localparam int LEVEL_W = 4;

  localparam int unsigned PERIOD_BASE  = 1000;
  localparam int unsigned PERIOD_STEP  = 60;
  localparam int unsigned PERIOD_FLOOR = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } drop_state_t;

  // Drop period in base ticks: 1000 - 60*level, never below the floor.
  function automatic logic [10:0] period_ms(input logic [15:0] level);
    int unsigned dec;
    dec = 32'(level) * PERIOD_STEP;
    if (dec + PERIOD_FLOOR >= PERIOD_BASE) return 11'(PERIOD_FLOOR);
    return 11'(PERIOD_BASE - dec);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the 1 ms base tick. The counter only
// advances while iRUN is high and is forced to zero by iCLR.
module tick_prescaler #(
  parameter int PRESCALE = 50_000
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iCLR,
  input  logic iRUN,
  output logic oTICK
);

  localparam int PC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(PRESCALE - 1);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (iCLR)      pc_d = '0;
    else if (iRUN) pc_d = (pc_q == PC_MAX) ? '0 : pc_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, matching the hardware.
  always_ff @(posedge iCLK) begin
    if (iRST) pc_q <= '0;
    else      pc_q <= pc_d;
  end

  assign oTICK = iRUN & (pc_q == PC_MAX);

endmodule

// File: rtl/tetris_drop_timer.sv
// Gravity-tick generator: level-dependent drop period, held drop request,
// pause/restart and sticky overrun. Optional soft-drop: TETRIS_SOFTDROP_EN.
module tetris_drop_timer
  import tetris_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BASE_HZ = 1000,
  parameter int LEVEL_W = tetris_pkg::LEVEL_W,
  parameter int SOFT_MS = 50
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEN,
  input  logic               iPAUSE,
  input  logic               iRESTART,
  input  logic [LEVEL_W-1:0] iLEVEL,
  input  logic               iSOFT,
  input  logic               iDROP_ACK,
  output logic               oDROP_REQ,
  output logic               oOVERRUN,
  output logic [1:0]         oSTATE
);

  localparam int PRESCALE = CLK_HZ / BASE_HZ;
  localparam logic [10:0] SOFT_P = 11'(SOFT_MS);

  drop_state_t state_q, state_d;
  logic [10:0] mc_q, mc_d;
  logic        req_q, req_d;
  logic        ovr_q, ovr_d;

  logic        base_tick, run_en, clr, expire;
  logic [10:0] period, eff_period;

  assign period = period_ms(16'(iLEVEL));

`ifdef TETRIS_SOFTDROP_EN
  assign eff_period = (iSOFT && (SOFT_P < period)) ? SOFT_P : period;
`else
  logic unused_soft;
  assign eff_period  = period;
  assign unused_soft = iSOFT | (SOFT_P == '0);
`endif

  // Counting is gated by the inputs of this edge, so an edge that carries
  // iPAUSE (or a restart/disable) never advances the timebase.
  assign clr    = ~iEN | iRESTART | (state_q == ST_IDLE);
  assign run_en = (state_q != ST_IDLE) & iEN & ~iRESTART & ~iPAUSE;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .iCLK (iCLK),
    .iRST (iRST),
    .iCLR (clr),
    .iRUN (run_en),
    .oTICK(base_tick)
  );

  // '>=' lets a shortened period expire on the very next base tick.
  assign expire = base_tick & (({1'b0, mc_q} + 12'd1) >= {1'b0, eff_period});

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (!iEN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = iPAUSE ? ST_PAUSED : ST_RUN;
        ST_RUN:    if (!iRESTART && iPAUSE)  state_d = ST_PAUSED;
        ST_PAUSED: if (!iRESTART && !iPAUSE) state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mc_d  = mc_q;
    req_d = req_q;
    ovr_d = ovr_q;
    if (!iEN || state_q == ST_IDLE) begin
      mc_d  = '0;
      req_d = 1'b0;
      ovr_d = 1'b0;
    end else if (iRESTART) begin
      mc_d  = '0;
      req_d = 1'b0;
    end else begin
      if (expire)         mc_d = '0;
      else if (base_tick) mc_d = mc_q + 11'd1;
      if (expire) begin
        req_d = 1'b1;
        if (req_q && !iDROP_ACK) ovr_d = 1'b1;
      end else if (iDROP_ACK) begin
        req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mc_q  <= '0;
      req_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      mc_q  <= mc_d;
      req_q <= req_d;
      ovr_q <= ovr_d;
    end
  end

  always_comb begin
    oDROP_REQ = req_q;
    oOVERRUN  = ovr_q;
    oSTATE    = state_q;
  end

endmodule

// File: tb/tb_tetris_drop_timer.sv
// Directed bench for tetris_drop_timer at PRESCALE=10; expected request
// latencies are queued with the stimulus and popped when the output rises.
module tb_tetris_drop_timer;

  localparam int CLK_HZ  = 10_000;
  localparam int BASE_HZ = 1000;
`ifdef TETRIS_SOFTDROP_EN
  localparam int SOFT_EXP = 500;
`else
  localparam int SOFT_EXP = 10_000;
`endif

  logic       iCLK = 1'b0;
  logic       iRST, iEN, iPAUSE, iRESTART, iSOFT, iDROP_ACK;
  logic [3:0] iLEVEL;
  logic       oDROP_REQ, oOVERRUN;
  logic [1:0] oSTATE;

  int edge_cnt = 0;
  int checks   = 0;
  int errors   = 0;
  int exp_q[$];
  int base;

  tetris_drop_timer #(
    .CLK_HZ (CLK_HZ),
    .BASE_HZ(BASE_HZ),
    .LEVEL_W(4),
    .SOFT_MS(50)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iEN      (iEN),
    .iPAUSE   (iPAUSE),
    .iRESTART (iRESTART),
    .iLEVEL   (iLEVEL),
    .iSOFT    (iSOFT),
    .iDROP_ACK(iDROP_ACK),
    .oDROP_REQ(oDROP_REQ),
    .oOVERRUN (oOVERRUN),
    .oSTATE   (oSTATE)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Waits (bounded) for the selected output to be high, then compares its
  // edge offset from the RUN-entry edge against the queued expectation.
  task automatic measure(input string tag, input bit want_ovr, input int from, input int bound);
    int n;
    logic [31:0] obs;
    n = 0;
    while (((want_ovr ? oOVERRUN : oDROP_REQ) !== 1'b1) && n < bound) begin
      @(negedge iCLK);
      n++;
    end
    obs = ((want_ovr ? oOVERRUN : oDROP_REQ) === 1'b1) ? 32'(edge_cnt - from) : 32'hFFFF_FFFF;
    check(tag, obs, 32'(exp_q.pop_front()));
  endtask

  task automatic ack_pulse();
    iDROP_ACK = 1'b1;
    step(1);
    iDROP_ACK = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] level, output int from);
    iLEVEL = level;
    iEN    = 1'b1;
    step(1);
    from = edge_cnt;
  endtask

  task automatic go_idle();
    iEN    = 1'b0;
    iPAUSE = 1'b0;
    iSOFT  = 1'b0;
    step(1);
  endtask

  initial begin
    iRST = 1'b1; iEN = 1'b0; iPAUSE = 1'b0; iRESTART = 1'b0;
    iSOFT = 1'b0; iDROP_ACK = 1'b0; iLEVEL = 4'd0;
    step(2);
    check("rst_req", 32'(oDROP_REQ), 0);
    check("rst_ovr", 32'(oOVERRUN), 0);
    check("rst_state", 32'(oSTATE), 0);
    iRST = 1'b0;
    step(1);

    // Level 0 with prompt acks: requests every 10000 edges, no overrun.
    start_run(4'd0, base);
    check("a_state_run", 32'(oSTATE), 1);
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(k * 10_000);
      measure("a_req_rise", 1'b0, base, 10_100);
      ack_pulse();
      check("a_ack_clear", 32'(oDROP_REQ), 0);
    end
    check("a_no_overrun", 32'(oOVERRUN), 0);
    go_idle();
    check("a_state_idle", 32'(oSTATE), 0);

    // Level 15, never acked: request at 1000, overrun at 2000.
    start_run(4'd15, base);
    exp_q.push_back(1000);
    measure("b_req_rise", 1'b0, base, 1100);
    exp_q.push_back(2000);
    measure("b_ovr_rise", 1'b1, base, 1100);
    check("b_req_held", 32'(oDROP_REQ), 1);
    go_idle();
    check("b_ovr_idle_clr", 32'(oOVERRUN), 0);
    check("b_req_idle_clr", 32'(oDROP_REQ), 0);

    // 3000-edge pause from edge 4000 shifts the first request to 13000.
    start_run(4'd0, base);
    step(3999);
    iPAUSE = 1'b1;
    step(1000);
    check("c_state_paused", 32'(oSTATE), 2);
    check("c_req_low_paused", 32'(oDROP_REQ), 0);
    step(2000);
    iPAUSE = 1'b0;
    exp_q.push_back(13_000);
    measure("c_req_rise", 1'b0, base, 7000);
    go_idle();

    // Restart sampled at edge 9000 moves the request to 19000.
    start_run(4'd0, base);
    step(8999);
    iRESTART = 1'b1;
    step(1);
    iRESTART = 1'b0;
    check("d_state_kept", 32'(oSTATE), 1);
    exp_q.push_back(19_000);
    measure("d_req_rise", 1'b0, base, 10_100);
    go_idle();

    // Level 0 -> 15 at mc=500: expiry on the next base tick, then 1000 later.
    start_run(4'd0, base);
    step(5000);
    iLEVEL = 4'd15;
    exp_q.push_back(5010);
    measure("e_req_fast", 1'b0, base, 100);
    ack_pulse();
    exp_q.push_back(6010);
    measure("e_req_next", 1'b0, base, 1100);
    check("e_no_overrun", 32'(oOVERRUN), 0);
    go_idle();
    iLEVEL = 4'd0;

    // Soft-drop held at level 0, then reset while a request is pending.
    iSOFT = 1'b1;
    start_run(4'd0, base);
    exp_q.push_back(SOFT_EXP);
    measure("f_soft_first", 1'b0, base, SOFT_EXP + 100);
`ifdef TETRIS_SOFTDROP_EN
    ack_pulse();
    exp_q.push_back(2 * SOFT_EXP);
    measure("f_soft_second", 1'b0, base, SOFT_EXP + 100);
`endif
    step(200);
    check("f_req_pending", 32'(oDROP_REQ), 1);
    iRST = 1'b1;
    step(1);
    check("f_rst_req", 32'(oDROP_REQ), 0);
    check("f_rst_ovr", 32'(oOVERRUN), 0);
    check("f_rst_state", 32'(oSTATE), 0);
    iRST = 1'b0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
